// File: rtl/l2_pmem_scheduler.sv
// l2_pmem_scheduler: write-back buffer and scheduler between the L2 and the single pmem port.
// Ports: L2 side (l2_pmem_read/write/addr/wdata, pmem_l2_resp/rdata); pmem side (pmem_read/write/addr/wdata, pmem_resp/rdata).
module l2_pmem_scheduler #(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         l2_pmem_read,
   input  logic         l2_pmem_write,
   input  logic [31:0]  l2_pmem_addr,
   input  logic [255:0] l2_pmem_wdata,
   output logic         pmem_l2_resp,
   output logic [255:0] pmem_l2_rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_addr,
   output logic [255:0] pmem_wdata,
   input  logic         pmem_resp,
   input  logic [255:0] pmem_rdata
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, RESP, READ_MEM, DRAIN} state_t;

   state_t          state;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;
   logic [DEPTH-1:0] valid;
   logic [26:0]     tag  [DEPTH];
   logic [255:0]    data [DEPTH];
   logic [255:0]    rdata_q;
   logic [26:0]     raddr_q;

   logic            hit;
   logic [PW-1:0]   hit_idx;
   logic            we_hit;
   logic            we_tail;
   logic            unused_addr_bits;

   assign unused_addr_bits = ^l2_pmem_addr[4:0];

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // Coalescing keeps at most one valid entry per tag.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && tag[i] == l2_pmem_addr[31:5]) begin
            hit     = 1'b1;
            hit_idx = PW'(i);
         end
      end
   end

   // Reads take priority over a simultaneous write.
   always_comb begin
      we_hit  = 1'b0;
      we_tail = 1'b0;
      if (state == IDLE && !l2_pmem_read && l2_pmem_write) begin
         we_hit  = hit;
         we_tail = !hit && (count != FULL);
      end
   end

   // Entry payload carries no reset; validity alone qualifies it.
   always_ff @(posedge clk) begin
      if (we_hit) begin
         data[hit_idx] <= l2_pmem_wdata;
      end else if (we_tail) begin
         tag[tail]  <= l2_pmem_addr[31:5];
         data[tail] <= l2_pmem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         valid   <= '0;
         rdata_q <= '0;
         raddr_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (l2_pmem_read) begin
                  if (hit) begin
                     rdata_q <= data[hit_idx];
                     state   <= RESP;
                  end else begin
                     raddr_q <= l2_pmem_addr[31:5];
                     state   <= READ_MEM;
                  end
               end else if (l2_pmem_write) begin
                  if (we_hit) begin
                     state <= RESP;
                  end else if (we_tail) begin
                     valid[tail] <= 1'b1;
                     tail        <= nxt(tail);
                     count       <= count + 1'b1;
                     state       <= RESP;
                  end else begin
                     // Full and no coalesce: free a slot, retry the write.
                     state <= DRAIN;
                  end
               end else if (count != '0) begin
                  state <= DRAIN;
               end
            end
            RESP: state <= IDLE;
            READ_MEM: begin
               if (pmem_resp) state <= IDLE;
            end
            DRAIN: begin
               if (pmem_resp) begin
                  valid[head] <= 1'b0;
                  head        <= nxt(head);
                  count       <= count - 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr     = '0;
      pmem_wdata    = '0;
      pmem_l2_resp  = 1'b0;
      pmem_l2_rdata = rdata_q;
      unique case (state)
         RESP: pmem_l2_resp = 1'b1;
         READ_MEM: begin
            pmem_read     = 1'b1;
            pmem_addr     = {raddr_q, 5'b0};
            pmem_l2_resp  = pmem_resp;
            pmem_l2_rdata = pmem_rdata;
         end
         DRAIN: begin
            pmem_write = 1'b1;
            pmem_addr  = {tag[head], 5'b0};
            pmem_wdata = data[head];
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_l2_pmem_scheduler.sv
// tb_l2_pmem_scheduler: directed and randomized-latency checks of l2_pmem_scheduler.
// Ports: none; drives the DUT with a behavioural pmem model and L2 request task.
module tb_l2_pmem_scheduler;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         l2_pmem_read;
   logic         l2_pmem_write;
   logic [31:0]  l2_pmem_addr;
   logic [255:0] l2_pmem_wdata;
   logic         pmem_l2_resp;
   logic [255:0] pmem_l2_rdata;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_addr;
   logic [255:0] pmem_wdata;
   logic         pmem_resp;
   logic [255:0] pmem_rdata;

   l2_pmem_scheduler #(.DEPTH(2)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .l2_pmem_read(l2_pmem_read),
      .l2_pmem_write(l2_pmem_write),
      .l2_pmem_addr(l2_pmem_addr),
      .l2_pmem_wdata(l2_pmem_wdata),
      .pmem_l2_resp(pmem_l2_resp),
      .pmem_l2_rdata(pmem_l2_rdata),
      .pmem_read(pmem_read),
      .pmem_write(pmem_write),
      .pmem_addr(pmem_addr),
      .pmem_wdata(pmem_wdata),
      .pmem_resp(pmem_resp),
      .pmem_rdata(pmem_rdata)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int n_req = 0;
   int resp_total = 0;
   int both_cnt = 0;
   int lat_cfg = 2;
   int lat_cnt = 0;

   logic [255:0] mem_a [logic [31:0]];
   logic [255:0] ref_a [logic [31:0]];
   bit           ev_wr [$];
   logic [31:0]  ev_addr [$];
   logic [255:0] ev_data [$];

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] mem_rd(input logic [31:0] a);
      return mem_a.exists(a) ? mem_a[a] : {8{a}};
   endfunction

   function automatic logic [255:0] ref_rd(input logic [31:0] a);
      logic [31:0] l;
      l = {a[31:5], 5'b0};
      return ref_a.exists(l) ? ref_a[l] : {8{l}};
   endfunction

   // pmem model: responds lat_cfg cycles after a request appears.
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         pmem_resp = 1'b0;
         if (pmem_read && pmem_write) both_cnt++;
         if (pmem_read || pmem_write) begin
            if (lat_cnt >= lat_cfg) begin
               pmem_resp = 1'b1;
               lat_cnt   = 0;
               ev_wr.push_back(pmem_write);
               ev_addr.push_back(pmem_addr);
               ev_data.push_back(pmem_wdata);
               if (pmem_write) mem_a[pmem_addr] = pmem_wdata;
               else pmem_rdata = mem_rd(pmem_addr);
            end else begin
               lat_cnt++;
            end
         end else begin
            lat_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (pmem_l2_resp) resp_total++;
   end

   // Called at posedge+1; returns at posedge+1 with the request dropped.
   task automatic l2_op(input bit wr, input logic [31:0] a, input logic [255:0] d,
                        output int lat, output logic [255:0] rd, output logic pr);
      lat = -1;
      rd  = '0;
      pr  = 1'b0;
      n_req++;
      l2_pmem_read  = !wr;
      l2_pmem_write = wr;
      l2_pmem_addr  = a;
      l2_pmem_wdata = d;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (pmem_l2_resp) begin
            lat = i - 1;
            rd  = pmem_l2_rdata;
            pr  = pmem_resp;
            break;
         end
      end
      check_eq("op_done", lat >= 0, 1);
      @(posedge clk);
      #1;
      l2_pmem_read  = 1'b0;
      l2_pmem_write = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int lat;
      int n;
      logic [255:0] rd;
      logic pr;
      bit seen;
      logic [255:0] a5, d0, d1, d2, d3, d4, d5, d6;
      a5 = {32{8'hA5}};
      d0 = {8{32'hD0D0_0000}};
      d1 = {8{32'h1111_1111}};
      d2 = {8{32'h2222_2222}};
      d3 = {8{32'h3333_3333}};
      d4 = {8{32'h4444_4444}};
      d5 = {8{32'h5555_5555}};
      d6 = {8{32'h6666_6666}};

      rst_n         = 1'b0;
      l2_pmem_read  = 1'b0;
      l2_pmem_write = 1'b0;
      l2_pmem_addr  = '0;
      l2_pmem_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_read", pmem_read, 0);
      check_eq("rst_write", pmem_write, 0);
      check_eq("rst_resp", pmem_l2_resp, 0);
      check_eq("rst_addr", pmem_addr, 0);
      check_eq("rst_wdata", pmem_wdata, 0);
      check_eq("rst_rdata", pmem_l2_rdata, 0);
      @(posedge clk);
      #1;

      // Reset in the middle of a slow drain.
      lat_cfg = 10;
      l2_op(1, 32'h500, d0, lat, rd, pr);
      check_eq("wr500_lat", lat, 1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pmem_write) begin
            seen = 1;
            break;
         end
      end
      check_eq("drain_seen", seen, 1);
      check_eq("drain_addr", pmem_addr, 32'h500);
      check_eq("drain_data", pmem_wdata, d0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rstd_write", pmem_write, 0);
      check_eq("rstd_addr", pmem_addr, 0);
      check_eq("rstd_rdata", pmem_l2_rdata, 0);
      n = ev_addr.size();
      repeat (12) @(negedge clk);
      check_eq("rstd_noev", ev_addr.size(), n);
      lat_cfg = 2;
      @(posedge clk);
      #1;
      l2_op(0, 32'h500, '0, lat, rd, pr);
      check_eq("rd500_data", rd, {8{32'h500}});
      check_eq("rd500_lat", lat, 3);
      check_eq("rd500_ev", ev_addr.size(), n + 1);
      check_eq("rd500_kind", ev_wr[n], 0);

      // Evict then forward.
      n = ev_addr.size();
      l2_op(1, 32'h1040, a5, lat, rd, pr);
      check_eq("ev1040_lat", lat, 1);
      l2_op(0, 32'h1044, '0, lat, rd, pr);
      check_eq("fwd_lat", lat, 1);
      check_eq("fwd_data", rd, a5);
      check_eq("fwd_nopmem", ev_addr.size(), n);
      idle(10);
      check_eq("dr1040_ev", ev_addr.size(), n + 1);
      check_eq("dr1040_addr", ev_addr[n], 32'h1040);
      check_eq("dr1040_data", ev_data[n], a5);

      // Read priority over a full buffer.
      n = ev_addr.size();
      l2_op(1, 32'h100, d1, lat, rd, pr);
      check_eq("wr100_lat", lat, 1);
      l2_op(1, 32'h200, d2, lat, rd, pr);
      check_eq("wr200_lat", lat, 1);
      l2_op(0, 32'h2000, '0, lat, rd, pr);
      check_eq("miss_lat", lat, 3);
      check_eq("miss_pass", pr, 1);
      check_eq("miss_data", rd, {8{32'h2000}});
      check_eq("miss_first", ev_wr[n], 0);
      check_eq("miss_addr", ev_addr[n], 32'h2000);

      // Coalesce while full, then forced drain.
      l2_op(1, 32'h100, d3, lat, rd, pr);
      check_eq("coal_lat", lat, 1);
      check_eq("coal_nodrain", ev_addr.size(), n + 1);
      l2_op(1, 32'h300, d4, lat, rd, pr);
      check_eq("full_lat", lat, 5);
      check_eq("full_addr", ev_addr[n+1], 32'h100);
      check_eq("full_data", ev_data[n+1], d3);
      idle(20);
      check_eq("idle_ev", ev_addr.size(), n + 4);
      check_eq("idle_a0", ev_addr[n+2], 32'h200);
      check_eq("idle_d0", ev_data[n+2], d2);
      check_eq("idle_a1", ev_addr[n+3], 32'h300);
      check_eq("idle_d1", ev_data[n+3], d4);

      // Wrapped refill.
      n = ev_addr.size();
      l2_op(1, 32'h400, d5, lat, rd, pr);
      l2_op(1, 32'h600, d6, lat, rd, pr);
      l2_op(0, 32'h600, '0, lat, rd, pr);
      check_eq("wrap_fwd", rd, d6);
      check_eq("wrap_lat", lat, 1);
      idle(20);
      check_eq("wrap_ev", ev_addr.size(), n + 2);
      check_eq("wrap_a0", ev_addr[n], 32'h400);
      check_eq("wrap_a1", ev_addr[n+1], 32'h600);

      // Random pmem latency with a coherent memory reference.
      for (int k = 0; k < 40; k++) begin
         bit wr;
         logic [31:0] a;
         logic [255:0] d;
         lat_cfg = $urandom_range(0, 10);
         wr = $urandom_range(0, 1) == 1;
         a  = 32'h8000 + 32'($urandom_range(0, 3)) * 32'h20 + 32'($urandom_range(0, 31));
         d  = {8{$urandom}};
         l2_op(wr, a, d, lat, rd, pr);
         if (wr) ref_a[{a[31:5], 5'b0}] = d;
         else check_eq("rnd_rdata", rd, ref_rd(a));
         idle($urandom_range(0, 3));
      end
      idle(40);
      check_eq("never_both", both_cnt, 0);
      check_eq("one_resp_each", resp_total, n_req);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
